sa_vc_arbiter: RTL and testbench
================================

// Module: sa_vc_arbiter
// PURPOSE
//  - First-stage (per-input-port) switch-allocation arbiter: selects one VC among V ready VCs of an input port.
//  - Forwards the winner's one-hot output-port request to the 5x5 main switch allocator.
//  - Returns the port-level grant to the winning VC as a flit-pop strobe.
//  - Keeps round-robin fairness state and, optionally, wormhole packet lock across cycles.
// PARAMETERS
//  V      4  VCs per input port (>=2)
//  N      5  router ports (width of one-hot output-port vectors)
//  VW     2  clog2(V), width of VC index
// PORTS
//  clk           in   1    router clock
//  rst           in   1    asynchronous reset, active-high
//  vcReq         in   V    VC v holds a flit and has downstream credit
//  vcOutPort     in   V*N  one-hot route of VC v at bits [v*N +: N]
//  vcTail        in   V    flit at head of VC v is a tail (single-flit pkt: head=tail)
//  reqSA         out  N    one-hot port request to main allocator; 0 = none
//  inputGrantSA  in   1    main allocator granted this input port (same cycle as reqSA)
//  vcGrant       out  V    one-hot; VC v pops one flit this cycle
//  selVC         out  VW   index of current local winner (valid when |reqSA)
//  locked        out  1    packet lock active (0 when SA_PKT_LOCK_EN undefined)
// BEHAVIOUR
//  - Eligibility: elig[v] = vcReq[v] & (vcOutPort[v] is exactly one-hot); zero/multi-hot route = not eligible.
//  - Local arbitration is combinational, round-robin from pointer ptr.
//    - Winner = first eligible v scanning ptr, ptr+1, ..., wrapping V-1 -> 0.
//  - reqSA  = vcOutPort[winner] if any eligible, else 0.
//  - selVC  = winner index, 0 when none.
//  - vcGrant = onehot(winner) & {V{inputGrantSA & |reqSA}}; zero-latency handshake, one flit per grant cycle.
//  - inputGrantSA while reqSA==0: ignored (no grant, no state change); bench flags protocol error.
//  - Pointer update (registered, next edge): on grant, ptr <= (winner==V-1) ? 0 : winner+1.
//    - No grant: ptr holds.
//    - Denied request: ptr holds, same VC re-requests next cycle.
//  - Reset: ptr=0, state=IDLE.
//    - While rst=1: reqSA=0, vcGrant=0, selVC=0, locked=0.
//    - rst mid-packet drops any lock immediately; no flit popped.
//  - Deassert rst synchronously to clk (external sync); first arbitration on first edge after release.
// CONFIGURATION
//  - Macro SA_PKT_LOCK_EN.
//  - Defined: FSM {IDLE, LOCK}, plus lockVC register (VW bits).
//    - IDLE: granted flit non-tail -> LOCK, lockVC<=winner.
//    - IDLE: granted flit is tail -> stay IDLE.
//    - LOCK: only lockVC eligible; others masked.
//      - lockVC not ready -> reqSA=0 bubble, stay LOCK.
//      - Grant of tail flit -> IDLE, ptr<=lockVC+1 (wrap).
//      - Grant of non-tail flit -> stay LOCK, ptr unchanged.
//    - locked = (state==LOCK).
//  - Undefined: no FSM; flit-level round-robin; locked tied 0; VCs may interleave at SA.
// TESTING
//  1. rst=1, vcReq=4'hF -> reqSA=0, vcGrant=0; release, ptr=0 -> selVC=0, reqSA=VC0 route.
//  2. vcReq=4'hF all routes 5'b00010, grant every cycle -> vcGrant 1,2,4,8,1 (wrap V-1->0).
//  3. vcReq=4'h5, inputGrantSA=0 for 3 cycles then 1 -> selVC=0 held 4 cycles, then vcGrant=4'h1, next selVC=2.
//  4. vcReq=4'h3, VC0 route 5'b00000, VC1 route 5'b00100 -> selVC=1, reqSA=5'b00100.
//  5. LOCK_EN: VC1 3-flit pkt, VC2 ready; grant all -> vcGrant 2,2,2 then 4; locked=1 after first grant, clears after tail.
//  6. LOCK_EN: VC1 locked, vcReq[1]=0 one cycle, VC0 ready -> reqSA=0 that cycle.
//     - Assert rst mid-packet -> locked=0 at once; after release selVC=0.

Source files
------------

// File: rtl/sa_vc_arbiter.sv
// Per-input-port switch-allocation VC arbiter: round-robin pick among eligible VCs, forwards the
// winner's route to the main allocator and returns its grant. Optional packet lock: SA_PKT_LOCK_EN.
module sa_vc_arbiter #(
  parameter int V  = 4,
  parameter int N  = 5,
  parameter int VW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [V-1:0]   vcReq,
  input  logic [V*N-1:0] vcOutPort,
  input  logic [V-1:0]   vcTail,
  output logic [N-1:0]   reqSA,
  input  logic           inputGrantSA,
  output logic [V-1:0]   vcGrant,
  output logic [VW-1:0]  selVC,
  output logic           locked
);

  logic [VW-1:0] ptr_q;
  logic [V-1:0]  elig;
  logic [V-1:0]  elig_m;
  logic [VW-1:0] win;
  logic          any;
  logic          gnt;
  logic [VW-1:0] ptr_nxt;
  logic [N-1:0]  route;
  int unsigned   scan_idx;

  // A route counts only if it is exactly one-hot; zero or multi-hot routes are ignored.
  always_comb begin
    elig  = '0;
    route = '0;
    for (int v = 0; v < V; v++) begin
      route   = vcOutPort[v*N +: N];
      elig[v] = vcReq[v] && (route != '0) && ((route & (route - 1'b1)) == '0);
    end
  end

  always_comb begin
    any      = 1'b0;
    win      = '0;
    scan_idx = 0;
    for (int i = 0; i < V; i++) begin
      scan_idx = int'(ptr_q) + i;
      if (scan_idx >= V) scan_idx = scan_idx - V;
      if (!any && elig_m[scan_idx]) begin
        any = 1'b1;
        win = VW'(scan_idx);
      end
    end
  end

  always_comb begin
    reqSA = '0;
    if (!rst && any) reqSA = vcOutPort[int'(win)*N +: N];
    gnt     = inputGrantSA && (reqSA != '0);
    vcGrant = gnt ? (V'(1) << win) : '0;
    selVC   = rst ? '0 : win;
    ptr_nxt = (int'(win) == V - 1) ? '0 : win + 1'b1;
  end

`ifdef SA_PKT_LOCK_EN
  typedef enum logic [0:0] {StIdle, StLock} state_e;

  state_e        state_q;
  logic [VW-1:0] lock_vc_q;

  // While a packet is in flight only its VC may compete.
  assign elig_m = (state_q == StLock) ? (elig & (V'(1) << lock_vc_q)) : elig;
  assign locked = (state_q == StLock);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      lock_vc_q <= '0;
      ptr_q     <= '0;
    end else if (gnt) begin
      unique case (state_q)
        StIdle: begin
          ptr_q <= ptr_nxt;
          if (!vcTail[win]) begin
            state_q   <= StLock;
            lock_vc_q <= win;
          end
        end
        StLock: begin
          if (vcTail[win]) begin
            state_q <= StIdle;
            ptr_q   <= ptr_nxt;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
`else
  logic unused_tail;

  assign unused_tail = ^vcTail;
  assign elig_m      = elig;
  assign locked      = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (gnt) begin
      ptr_q <= ptr_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_sa_vc_arbiter.sv
// Directed, table-driven bench for sa_vc_arbiter; lock sequences run when SA_PKT_LOCK_EN is defined.
module tb_sa_vc_arbiter;

  localparam int V  = 4;
  localparam int N  = 5;
  localparam int VW = 2;

  localparam logic [V*N-1:0] ALL  = {4{5'b00010}};
  localparam logic [V*N-1:0] DIST = {5'b01000, 5'b00100, 5'b00010, 5'b00001};
  localparam logic [V*N-1:0] T4A  = {5'b00000, 5'b00000, 5'b00100, 5'b00000};
  localparam logic [V*N-1:0] T4B  = {5'b00000, 5'b00000, 5'b00110, 5'b00001};

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [V-1:0]   vcReq = '0;
  logic [V*N-1:0] vcOutPort = '0;
  logic [V-1:0]   vcTail = '0;
  logic           inputGrantSA = 1'b0;
  logic [N-1:0]   reqSA;
  logic [V-1:0]   vcGrant;
  logic [VW-1:0]  selVC;
  logic           locked;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic           rst;
    logic [V-1:0]   req;
    logic [V*N-1:0] port;
    logic [V-1:0]   tail;
    logic           g;
    logic [N-1:0]   e_req;
    logic [V-1:0]   e_gnt;
    logic [VW-1:0]  e_sel;
    logic           e_lock;
    string          name;
  } vec_t;

  vec_t vecs[$];

  sa_vc_arbiter #(.V(V), .N(N), .VW(VW)) dut (
    .clk          (clk),
    .rst          (rst),
    .vcReq        (vcReq),
    .vcOutPort    (vcOutPort),
    .vcTail       (vcTail),
    .reqSA        (reqSA),
    .inputGrantSA (inputGrantSA),
    .vcGrant      (vcGrant),
    .selVC        (selVC),
    .locked       (locked)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic [V-1:0] q, input logic [V*N-1:0] p,
                              input logic [V-1:0] t, input logic g, input logic [N-1:0] er,
                              input logic [V-1:0] eg, input logic [VW-1:0] es, input logic el,
                              input string nm);
    vec_t x;
    x.rst = r; x.req = q; x.port = p; x.tail = t; x.g = g;
    x.e_req = er; x.e_gnt = eg; x.e_sel = es; x.e_lock = el; x.name = nm;
    return x;
  endfunction

  task automatic check_outs(input string nm, input logic [N-1:0] er, input logic [V-1:0] eg,
                            input logic [VW-1:0] es, input logic el);
    total += 4;
    if (reqSA !== er) begin
      bad++; $display("FAIL %s reqSA got=%b want=%b", nm, reqSA, er);
    end
    if (vcGrant !== eg) begin
      bad++; $display("FAIL %s vcGrant got=%b want=%b", nm, vcGrant, eg);
    end
    if (selVC !== es) begin
      bad++; $display("FAIL %s selVC got=%0d want=%0d", nm, selVC, es);
    end
    if (locked !== el) begin
      bad++; $display("FAIL %s locked got=%b want=%b", nm, locked, el);
    end
  endtask

  // Drive one cycle's inputs away from the rising edge and check settled outputs.
  task automatic apply(input vec_t x);
    @(negedge clk);
    rst = x.rst; vcReq = x.req; vcOutPort = x.port; vcTail = x.tail; inputGrantSA = x.g;
    #1;
    if (x.g && reqSA == '0 && !x.rst)
      $display("note: %s inputGrantSA with no request (protocol error, ignored)", x.name);
    check_outs(x.name, x.e_req, x.e_gnt, x.e_sel, x.e_lock);
  endtask

  initial begin
    // reset and release
    vecs.push_back(mk(1, 4'hF, DIST, 4'hF, 1, 5'b0,     4'h0, 0, 0, "rst_hold"));
    vecs.push_back(mk(0, 4'hF, DIST, 4'hF, 0, 5'b00001, 4'h0, 0, 0, "rel_vc0"));
    // round-robin wrap with grant every cycle
    vecs.push_back(mk(0, 4'hF, ALL, 4'hF, 1, 5'b00010, 4'h1, 0, 0, "rr0"));
    vecs.push_back(mk(0, 4'hF, ALL, 4'hF, 1, 5'b00010, 4'h2, 1, 0, "rr1"));
    vecs.push_back(mk(0, 4'hF, ALL, 4'hF, 1, 5'b00010, 4'h4, 2, 0, "rr2"));
    vecs.push_back(mk(0, 4'hF, ALL, 4'hF, 1, 5'b00010, 4'h8, 3, 0, "rr3"));
    vecs.push_back(mk(0, 4'hF, ALL, 4'hF, 1, 5'b00010, 4'h1, 0, 0, "rr_wrap"));
    vecs.push_back(mk(0, 4'h8, ALL, 4'hF, 1, 5'b00010, 4'h8, 3, 0, "vc3_to_ptr0"));
    // denied requests hold the winner
    vecs.push_back(mk(0, 4'h5, ALL, 4'hF, 0, 5'b00010, 4'h0, 0, 0, "deny0"));
    vecs.push_back(mk(0, 4'h5, ALL, 4'hF, 0, 5'b00010, 4'h0, 0, 0, "deny1"));
    vecs.push_back(mk(0, 4'h5, ALL, 4'hF, 0, 5'b00010, 4'h0, 0, 0, "deny2"));
    vecs.push_back(mk(0, 4'h5, ALL, 4'hF, 1, 5'b00010, 4'h1, 0, 0, "deny_grant"));
    vecs.push_back(mk(0, 4'h5, ALL, 4'hF, 0, 5'b00010, 4'h0, 2, 0, "after_deny"));
    vecs.push_back(mk(0, 4'h5, ALL, 4'hF, 1, 5'b00010, 4'h4, 2, 0, "grant_vc2"));
    // route eligibility (ptr=3)
    vecs.push_back(mk(0, 4'h3, T4A, 4'hF, 0, 5'b00100, 4'h0, 1, 0, "zero_route"));
    vecs.push_back(mk(0, 4'h3, T4B, 4'hF, 0, 5'b00001, 4'h0, 0, 0, "multi_hot"));
    vecs.push_back(mk(0, 4'h0, ALL, 4'hF, 1, 5'b0,     4'h0, 0, 0, "grant_no_req"));
    vecs.push_back(mk(0, 4'hF, ALL, 4'hF, 0, 5'b00010, 4'h0, 3, 0, "ptr_held"));
    vecs.push_back(mk(0, 4'hF, ALL, 4'hF, 1, 5'b00010, 4'h8, 3, 0, "to_ptr0"));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

`ifdef SA_PKT_LOCK_EN
    // 3-flit packet on VC1 holds the port against VC2
    apply(mk(0, 4'h6, ALL, 4'h4, 1, 5'b00010, 4'h2, 1, 0, "pkt_head"));
    apply(mk(0, 4'h6, ALL, 4'h4, 1, 5'b00010, 4'h2, 1, 1, "pkt_body"));
    apply(mk(0, 4'h6, ALL, 4'h6, 1, 5'b00010, 4'h2, 1, 1, "pkt_tail"));
    apply(mk(0, 4'h6, ALL, 4'h6, 1, 5'b00010, 4'h4, 2, 0, "pkt_next"));
    // ptr=3: lock VC1, then it stalls while VC0 waits
    apply(mk(0, 4'h2, ALL, 4'h0, 1, 5'b00010, 4'h2, 1, 0, "lk_head"));
    apply(mk(0, 4'h1, ALL, 4'h0, 1, 5'b0,     4'h0, 0, 1, "lk_bubble"));
    apply(mk(0, 4'h3, ALL, 4'h0, 1, 5'b00010, 4'h2, 1, 1, "lk_resume"));
    // asynchronous reset mid-packet
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_outs("rst_mid_pkt", 5'b0, 4'h0, 0, 0);
    apply(mk(0, 4'h3, ALL, 4'h0, 0, 5'b00010, 4'h0, 0, 0, "after_rst"));
`else
    // without packet lock, VCs interleave flit by flit
    apply(mk(0, 4'h6, ALL, 4'h0, 1, 5'b00010, 4'h2, 1, 0, "il_vc1"));
    apply(mk(0, 4'h6, ALL, 4'h0, 1, 5'b00010, 4'h4, 2, 0, "il_vc2"));
    apply(mk(0, 4'h6, ALL, 4'h0, 1, 5'b00010, 4'h2, 1, 0, "il_vc1b"));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_outs("rst_async", 5'b0, 4'h0, 0, 0);
    apply(mk(0, 4'h6, ALL, 4'h0, 0, 5'b00010, 4'h0, 1, 0, "after_rst"));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
